// File: rtl/uart_rx_controller.sv
// Receive-side sequencing FSM for the UART: detects the start bit, times mid-bit sampling
// from the oversample tick, and drives shift/parity/queue strobes plus error pulses.
module uart_rx_controller #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_clk_en,
    input  logic rx,
    input  logic parity_en,
    input  logic double_stop_bit,
    input  logic rx_parity_err,
    input  logic rx_queue_full,
    output logic rx_shift_reg_se,
    output logic rx_parity_reset,
    output logic rx_parity_we,
    output logic rx_queue_we,
    output logic frame_err,
    output logic parity_err,
    output logic overrun_err,
    output logic rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] MID_TICK  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] sample_cnt_r, sample_cnt_s;
    logic [BIT_W-1:0] bit_cnt_r, bit_cnt_s;
    logic             cfg_parity_r, cfg_parity_s;
    logic             cfg_double_r, cfg_double_s;
    logic             stop_bad_r, stop_bad_s;
    logic             armed_r;
    logic             busy_r;
    logic             sample_s;
    logic             complete_s;
    logic             stop_fail_s;

    // State, counters and latched frame configuration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            sample_cnt_r <= CNT_ZERO;
            bit_cnt_r    <= BIT_ZERO;
            cfg_parity_r <= 1'b0;
            cfg_double_r <= 1'b0;
            stop_bad_r   <= 1'b0;
            armed_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            sample_cnt_r <= sample_cnt_s;
            bit_cnt_r    <= bit_cnt_s;
            cfg_parity_r <= cfg_parity_s;
            cfg_double_r <= cfg_double_s;
            stop_bad_r   <= stop_bad_s;
            armed_r      <= 1'b1;
            busy_r       <= (state_s != IDLE);
        end
    end

    assign rx_busy = busy_r;

    // Next-state, counter updates and per-tick strobes; armed_r keeps the first clk after reset quiet.
    always_comb begin
        state_s         = state_r;
        sample_cnt_s    = sample_cnt_r;
        bit_cnt_s       = bit_cnt_r;
        cfg_parity_s    = cfg_parity_r;
        cfg_double_s    = cfg_double_r;
        stop_bad_s      = stop_bad_r;
        sample_s        = 1'b0;
        complete_s      = 1'b0;
        stop_fail_s     = 1'b0;
        rx_shift_reg_se = 1'b0;
        rx_parity_reset = 1'b0;
        rx_parity_we    = 1'b0;
        rx_queue_we     = 1'b0;
        frame_err       = 1'b0;
        parity_err      = 1'b0;
        overrun_err     = 1'b0;

        if (rx_clk_en && armed_r) begin
            if (state_r == START) begin
                sample_s = (sample_cnt_r == MID_TICK);
            end else begin
                sample_s = (sample_cnt_r == LAST_TICK);
            end

            if (sample_s) begin
                sample_cnt_s = CNT_ZERO;
            end else begin
                sample_cnt_s = sample_cnt_r + CNT_ONE;
            end

            case (state_r)
                IDLE: begin
                    sample_cnt_s = CNT_ZERO;
                    if (!rx) begin
                        rx_parity_reset = 1'b1;
                        cfg_parity_s    = parity_en;
                        cfg_double_s    = double_stop_bit;
                        stop_bad_s      = 1'b0;
                        state_s         = START;
                    end else begin
                        state_s = IDLE;
                    end
                end
                START: begin
                    if (sample_s && rx) begin
                        state_s = IDLE;
                    end else if (sample_s) begin
                        bit_cnt_s = BIT_ZERO;
                        state_s   = DATA;
                    end else begin
                        state_s = START;
                    end
                end
                DATA: begin
                    if (sample_s) begin
                        rx_shift_reg_se = 1'b1;
                        rx_parity_we    = 1'b1;
                        bit_cnt_s       = bit_cnt_r + BIT_ONE;
                        if (bit_cnt_r == LAST_BIT) begin
                            state_s = cfg_parity_r ? PARITY : STOP1;
                        end else begin
                            state_s = DATA;
                        end
                    end else begin
                        state_s = DATA;
                    end
                end
                PARITY: begin
                    if (sample_s) begin
                        rx_parity_we = 1'b1;
                        state_s      = STOP1;
                    end else begin
                        state_s = PARITY;
                    end
                end
                STOP1: begin
                    if (sample_s && cfg_double_r) begin
                        stop_bad_s = ~rx;
                        state_s    = STOP2;
                    end else if (sample_s) begin
                        complete_s  = 1'b1;
                        stop_fail_s = ~rx;
                        state_s     = IDLE;
                    end else begin
                        state_s = STOP1;
                    end
                end
                STOP2: begin
                    if (sample_s) begin
                        complete_s  = 1'b1;
                        stop_fail_s = stop_bad_r | ~rx;
                        state_s     = IDLE;
                    end else begin
                        state_s = STOP2;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase

            // Exactly one completion outcome, frame error taking precedence over parity over overrun.
            if (complete_s) begin
                if (stop_fail_s) begin
                    frame_err = 1'b1;
                end else if (cfg_parity_r && rx_parity_err) begin
                    parity_err = 1'b1;
                end else if (rx_queue_full) begin
                    overrun_err = 1'b1;
                end else begin
                    rx_queue_we = 1'b1;
                end
            end else begin
                rx_queue_we = 1'b0;
            end
        end else begin
            state_s = state_r;
        end
    end

endmodule
